// File: rtl/axum_uart_pkg.sv
// rtl/axum_uart_pkg.sv - shared UART transmit/receive types and defaults
//
// Holds the serial FSM state encoding, the default frame geometry and a
// small width helper used by both UART directions.
package axum_uart_pkg;

  // Default data bits per frame and stop-bit length in baud ticks.
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  // Start and data bits each last this many baud ticks.
  localparam int OVERSAMPLE  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axum_uart_fifo.sv
// rtl/axum_uart_fifo.sv - synchronous FIFO feeding the UART transmitter
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset, empties the FIFO
//   push   - write request, ignored while full
//   pop    - read request, ignored while empty
//   wdata  - write data
//   rdata  - head entry (valid while !empty)
//   full   - no room; derived from registered pointers only
//   empty  - no entries; derived from registered pointers only
module axum_uart_fifo #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates "wrapped once" (full) from "equal" (empty).
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Gating on registered flags: a same-cycle pop never frees space for a
  // push into a full FIFO, and a push into an empty FIFO is not visible to
  // the reader until the following cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/axum_uart_tx.sv
// rtl/axum_uart_tx.sv - buffered UART transmitter with programmable baud divisor
//
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - asynchronous active-high reset, aborts any frame
//   tx_valid_i - byte offered for transmission
//   tx_data_i  - byte to transmit
//   tx_ready_o - FIFO can accept (handshake on valid & ready)
//   dvsr_i     - baud divisor, tick period is dvsr_i+1 clocks
//   tx_o       - serial line, idle high
//   tx_busy_o  - frame in progress
//   tx_empty_o - FIFO empty
//   tx_done_o  - one-cycle pulse at the end of each stop bit
module axum_uart_tx
  import axum_uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int FIFO_W  = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tx_valid_i,
  input  logic [DBIT-1:0] tx_data_i,
  output logic            tx_ready_o,
  input  logic [31:0]     dvsr_i,
  output logic            tx_o,
  output logic            tx_busy_o,
  output logic            tx_empty_o,
  output logic            tx_done_o
);

  localparam int TW = cnt_w((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int NW = cnt_w(DBIT);

  localparam logic [TW-1:0] S_ONE       = TW'(1);
  localparam logic [TW-1:0] S_BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] S_STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_ONE       = NW'(1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  uart_state_e     state_q;
  logic [31:0]     cnt_q;
  logic            tick;
  logic [TW-1:0]   s_q;
  logic [NW-1:0]   n_q;
  logic [DBIT-1:0] shift_q;
  logic            tx_q;
  logic            done_q;

  logic            fifo_pop;
  logic [DBIT-1:0] fifo_rdata;
  logic            fifo_full;
  logic            fifo_empty;
  logic            stop_end;

  axum_uart_fifo #(
    .WIDTH  (DBIT),
    .ADDR_W (FIFO_W)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (tx_valid_i),
    .pop   (fifo_pop),
    .wdata (tx_data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Using >= rather than == lets a divisor lowered below the running count
  // end the current tick on the next cycle instead of counting to 2**32.
  assign tick = (state_q != IDLE) && (cnt_q >= dvsr_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_q == IDLE || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stop_end = (state_q == STOP) && tick && (s_q == S_STOP_LAST);

  // Head is taken either to start from idle or to chain straight into the
  // next frame at the last stop-bit tick.
  assign fifo_pop = !fifo_empty && ((state_q == IDLE) || stop_end);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Line level follows the current state, so it trails state by one
      // cycle; every bit keeps its full length on the wire.
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shift_q[0];
        default: tx_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shift_q <= fifo_rdata;
            s_q     <= '0;
            n_q     <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (tick) begin
            if (s_q == S_BIT_LAST) begin
              s_q     <= '0;
              n_q     <= '0;
              state_q <= DATA;
            end else begin
              s_q <= s_q + S_ONE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_q == S_BIT_LAST) begin
              s_q     <= '0;
              shift_q <= shift_q >> 1;
              if (n_q == N_LAST) begin
                state_q <= STOP;
              end else begin
                n_q <= n_q + N_ONE;
              end
            end else begin
              s_q <= s_q + S_ONE;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_q == S_STOP_LAST) begin
              s_q    <= '0;
              done_q <= 1'b1;
              if (!fifo_empty) begin
                shift_q <= fifo_rdata;
                n_q     <= '0;
                state_q <= START;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_q <= s_q + S_ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_o       = tx_q;
  assign tx_done_o  = done_q;
  assign tx_busy_o  = (state_q != IDLE);
  assign tx_empty_o = fifo_empty;
  assign tx_ready_o = !fifo_full;

endmodule

// File: tb/tb_axum_uart_tx.sv
// tb/tb_axum_uart_tx.sv - directed self-checking bench for axum_uart_tx
module tb_axum_uart_tx;

  logic        clk;
  logic        rst;
  logic        valid_a, valid_b;
  logic [7:0]  data_a, data_b;
  logic [31:0] dvsr_a, dvsr_b;
  logic        ready_a, tx_a, busy_a, empty_a, done_a;
  logic        ready_b, tx_b, busy_b, empty_b, done_b;

  int n_cmp = 0;
  int n_err = 0;
  int t = 0;
  logic mon_en = 1'b0;
  logic [7:0] rx_q [$];
  logic [7:0] fill [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] exp_rx [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  axum_uart_tx #(.FIFO_W(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .tx_valid_i(valid_a), .tx_data_i(data_a),
    .tx_ready_o(ready_a), .dvsr_i(dvsr_a), .tx_o(tx_a), .tx_busy_o(busy_a),
    .tx_empty_o(empty_a), .tx_done_o(done_a)
  );

  axum_uart_tx #(.FIFO_W(2), .SB_TICK(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .tx_valid_i(valid_b), .tx_data_i(data_b),
    .tx_ready_o(ready_b), .dvsr_i(dvsr_b), .tx_o(tx_b), .tx_busy_o(busy_b),
    .tx_empty_o(empty_b), .tx_done_o(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 0) ? done_a : done_b;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy_a : busy_b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after edge N+target, N being the last acceptance edge.
  task automatic go(input int target);
    repeat (target - t) @(posedge clk);
    #1;
    t = target;
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    if (sel == 0) begin
      valid_a = 1'b1; data_a = d; chk("push_ready_a", ready_a, 1);
    end else begin
      valid_b = 1'b1; data_b = d; chk("push_ready_b", ready_b, 1);
    end
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    t = 0;
  endtask

  // Full-frame check at dvsr 0 for a byte accepted at edge N into an idle DUT.
  task automatic frame(input int sel, input logic [7:0] b, input int sb, input string tag);
    go(1);  chk({tag, "_n1_idle"}, tx_of(sel), 1);
    go(2);  chk({tag, "_n2_start"}, tx_of(sel), 0);
    go(17); chk({tag, "_start_last"}, tx_of(sel), 0);
    for (int i = 0; i < 8; i++) begin
      go(18 + 16 * i); chk($sformatf("%s_b%0d_first", tag, i), tx_of(sel), b[i]);
      go(33 + 16 * i); chk($sformatf("%s_b%0d_last", tag, i), tx_of(sel), b[i]);
    end
    go(146);      chk({tag, "_stop_first"}, tx_of(sel), 1);
    go(144 + sb); chk({tag, "_done_early"}, done_of(sel), 0);
    chk({tag, "_stop_last"}, tx_of(sel), 1);
    go(145 + sb); chk({tag, "_done"}, done_of(sel), 1);
    go(146 + sb); chk({tag, "_done_end"}, done_of(sel), 0);
    chk({tag, "_idle"}, busy_of(sel), 0);
    chk({tag, "_line_high"}, tx_of(sel), 1);
  endtask

  // Serial decoder for dut_a at dvsr 0; samples the middle of each data bit.
  initial begin : mon
    logic prev;
    logic [7:0] acc;
    prev = 1'b1;
    acc = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && prev && !tx_a) begin
        repeat (24) @(posedge clk);
        #1;
        acc[0] = tx_a;
        for (int i = 1; i < 8; i++) begin
          repeat (16) @(posedge clk);
          #1;
          acc[i] = tx_a;
        end
        repeat (16) @(posedge clk);
        #1;
        rx_q.push_back(acc);
      end
      prev = tx_a;
    end
  end

  initial begin : stim
    logic found;
    logic bad;
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0; data_b = '0;
    dvsr_a = '0; dvsr_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_a", tx_a, 1);     chk("rst_tx_b", tx_b, 1);
    chk("rst_busy_a", busy_a, 0); chk("rst_busy_b", busy_b, 0);
    chk("rst_done_a", done_a, 0); chk("rst_done_b", done_b, 0);
    chk("rst_empty_a", empty_a, 1); chk("rst_empty_b", empty_b, 1);
    chk("rst_ready_a", ready_a, 1); chk("rst_ready_b", ready_b, 1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single 0xA5 frame, one tick per clock.
    push(0, 8'hA5);
    frame(0, 8'hA5, 16, "a5");

    // 0x00 then 0xFF back to back at dvsr 1.
    dvsr_a = 32'd1;
    valid_a = 1'b1; data_a = 8'h00;
    @(posedge clk); #1;
    data_a = 8'hFF;
    @(posedge clk); #1;
    valid_a = 1'b0; t = 1;
    chk("b2b_second_queued", empty_a, 0);
    go(2);   chk("b2b_f1_start", tx_a, 0);
    go(50);  chk("b2b_f1_bit0", tx_a, 0);
    go(289); chk("b2b_f1_bit7", tx_a, 0);
    go(290); chk("b2b_f1_stop", tx_a, 1);
    go(320); chk("b2b_f1_done_early", done_a, 0);
    go(321); chk("b2b_f1_done", done_a, 1);
    chk("b2b_f1_stop_last", tx_a, 1);
    go(322); chk("b2b_f1_done_end", done_a, 0);
    chk("b2b_f2_start_nogap", tx_a, 0);
    chk("b2b_busy", busy_a, 1);
    go(466); chk("b2b_f2_bit3", tx_a, 1);
    go(641); chk("b2b_f2_done", done_a, 1);
    go(642); chk("b2b_idle", busy_a, 0);
    chk("b2b_empty", empty_a, 1);

    // Stall the FSM in START, then fill the 4-entry FIFO.
    dvsr_a = 32'hFFFF;
    push(0, 8'h11);
    go(2);
    chk("stall_busy", busy_a, 1);
    chk("stall_head_taken", empty_a, 1);
    valid_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data_a = fill[k];
      chk($sformatf("fill_ready%0d", k), ready_a, (k < 4));
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("full_hold_ready%0d", k), ready_a, 0);
      @(posedge clk); #1;
    end
    chk("full_not_empty", empty_a, 0);

    // Release the stall with 0x66 still offered; it must enter only after the pop.
    dvsr_a = 32'd0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(posedge clk); #1;
      if (done_a) found = 1'b1;
    end
    chk("full_first_done", found, 1);
    mon_en = 1'b1;
    chk("pop_cycle_ready", ready_a, 1);
    @(posedge clk); #1;
    chk("push_after_pop_full", ready_a, 0);
    valid_a = 1'b0;
    for (int c = 0; c < 1200 && rx_q.size() < 5; c++) @(posedge clk);
    #1;
    chk("rx_count", rx_q.size(), 5);
    for (int k = 0; k < 5; k++) begin
      if (k < rx_q.size()) chk($sformatf("rx_byte%0d", k), rx_q[k], exp_rx[k]);
    end
    for (int c = 0; c < 200 && busy_a; c++) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("drain_idle", busy_a, 0);
    chk("drain_empty", empty_a, 1);

    // Reset in the middle of the data bits of 0x3C with 0x99 still queued.
    valid_a = 1'b1; data_a = 8'h3C;
    @(posedge clk); #1;
    data_a = 8'h99;
    @(posedge clk); #1;
    valid_a = 1'b0; t = 1;
    go(82);
    chk("abort_pre_busy", busy_a, 1);
    chk("abort_pre_queued", empty_a, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_tx", tx_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_empty", empty_a, 1);
    chk("abort_done", done_a, 0);
    chk("abort_ready", ready_a, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (done_a || !tx_a || busy_a) bad = 1'b1;
    end
    chk("abort_quiet", bad, 0);
    push(0, 8'h81);
    frame(0, 8'h81, 16, "x81");

    // Two-stop-bit instance.
    push(1, 8'h55);
    frame(1, 8'h55, 32, "sb32");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
